// File: rtl/bf16_mul_arbiter.sv
// Round-robin arbiter sharing one two-stage bf16 multiplier among NUM_REQ requesters.
// Optional BF16_ARB_STATS_EN adds op_count / stall_count performance counters.
module bf16_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [16*NUM_REQ-1:0]  req_a,
    input  logic [16*NUM_REQ-1:0]  req_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            out_product,
    output logic [ID_W-1:0]        out_id
`ifdef BF16_ARB_STATS_EN
    ,
    output logic [31:0]            op_count,
    output logic [31:0]            stall_count
`endif
);

    // Truncating bf16 multiply; bit-exact with the existing multiplier, no special values.
    function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        sign;
        logic [7:0]  ma;
        logic [7:0]  mb;
        logic [7:0]  exp;
        logic [15:0] prod;
        logic [6:0]  man;
        sign = a[15] ^ b[15];
        ma   = {|a[14:7], a[6:0]};
        mb   = {|b[14:7], b[6:0]};
        prod = {8'd0, ma} * {8'd0, mb};
        // 129 == -127 mod 256
        exp  = a[14:7] + b[14:7] + 8'd129;
        if (prod[15]) begin
            man = prod[14:8];
            exp = exp + 8'd1;
        end else begin
            man = prod[13:7];
        end
        if (prod == 16'd0) bf16_mul = 16'h0000;
        else               bf16_mul = {sign, exp, man};
    endfunction

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic            any_req;
    logic            accept;
    logic            s1_valid;
    logic            s1_adv;
    logic            s2_adv;
    logic [15:0]     s1_a;
    logic [15:0]     s1_b;
    logic [ID_W-1:0] s1_id;
    logic [15:0]     s1_product;
    int              idx;

    assign s2_adv = !out_valid || out_ready;
    assign s1_adv = !s1_valid || s2_adv;
    assign accept = any_req && s1_adv;

    always_comb begin
        any_req = 1'b0;
        grant   = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!any_req && req_valid[idx]) begin
                any_req = 1'b1;
                grant   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant] = 1'b1;
    end

    // ---- S1: operand register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            rr_ptr   <= '0;
        end else if (s1_adv) begin
            s1_valid <= accept;
            if (accept) rr_ptr <= ID_W'((int'(grant) + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a  <= req_a[16*int'(grant) +: 16];
            s1_b  <= req_b[16*int'(grant) +: 16];
            s1_id <= grant;
        end
    end

    assign s1_product = bf16_mul(s1_a, s1_b);

    // ---- S2: result register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_product <= 16'h0000;
            out_id      <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_product <= s1_product;
                out_id      <= s1_id;
            end
        end
    end

`ifdef BF16_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count    <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (out_valid && out_ready)  op_count    <= op_count + 32'd1;
            if (out_valid && !out_ready) stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bf16_mul_arbiter.sv
// Directed-vector bench for bf16_mul_arbiter (NUM_REQ=4); stats checks when BF16_ARB_STATS_EN is defined.
module tb_bf16_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [15:0]           out_product;
    logic [ID_W-1:0]       out_id;
`ifdef BF16_ARB_STATS_EN
    logic [31:0]           op_count;
    logic [31:0]           stall_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    bf16_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_id      (out_id)
`ifdef BF16_ARB_STATS_EN
        ,
        .op_count    (op_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic reset_pulse();
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
    endtask

    logic [15:0] rr_prod [4];
    int          acc;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_product", 32'(out_product), 32'h0000);
        check("rst_out_id", 32'(out_id), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;

        // single request: 1.5 * 2.0 = 3.0
        tick();
        set_op(0, 16'h3FC0, 16'h4000);
        req_valid = 4'b0001;
        out_ready = 1'b1;
        #1 check("single_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        check("single_lat_early", 32'(out_valid), 32'd0);
        tick();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_product", 32'(out_product), 32'h4040);
        check("single_id", 32'(out_id), 32'd0);
        tick();
        check("single_drain", 32'(out_valid), 32'd0);

        // round robin with all requesters busy
        reset_pulse();
        set_op(0, 16'h3F80, 16'h4000);
        set_op(1, 16'h3F80, 16'h4040);
        set_op(2, 16'h3F80, 16'h4080);
        set_op(3, 16'h4000, 16'h4040);
        rr_prod[0] = 16'h4000;
        rr_prod[1] = 16'h4040;
        rr_prod[2] = 16'h4080;
        rr_prod[3] = 16'h40C0;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1 check("rr_grant", 32'(req_ready), 32'(1 << (c % 4)));
            if (c >= 2) begin
                check("rr_valid", 32'(out_valid), 32'd1);
                check("rr_id", 32'(out_id), 32'((c - 2) % 4));
                check("rr_product", 32'(out_product), 32'(rr_prod[(c - 2) % 4]));
            end
            tick();
        end
        req_valid = 4'b0000;
        tick();
        tick();
        tick();
        check("rr_drain", 32'(out_valid), 32'd0);

        // backpressure, then drain in order; also zero and sign cases
        reset_pulse();
        set_op(1, 16'h4000, 16'h4040);
        set_op(2, 16'hBF80, 16'h3F80);
        set_op(0, 16'h0000, 16'h4000);
        req_valid = 4'b0110;
        out_ready = 1'b0;
        #1 check("bp_grant1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0100;
        #1 check("bp_grant2", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0001;
        #1 check("bp_full_ready", 32'(req_ready), 32'h0);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_id", 32'(out_id), 32'd1);
        check("bp_product", 32'(out_product), 32'h40C0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp_hold_ready", 32'(req_ready), 32'h0);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_product", 32'(out_product), 32'h40C0);
            check("bp_hold_id", 32'(out_id), 32'd1);
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        check("bp_drain2_valid", 32'(out_valid), 32'd1);
        check("bp_drain2_id", 32'(out_id), 32'd2);
        check("bp_sign_product", 32'(out_product), 32'hBF80);
        tick();
        check("bp_drain3_valid", 32'(out_valid), 32'd1);
        check("bp_drain3_id", 32'(out_id), 32'd0);
        check("bp_zero_product", 32'(out_product), 32'h0000);
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);

        // reset with two results in flight
        reset_pulse();
        set_op(0, 16'h3F80, 16'h3F80);
        set_op(3, 16'h4000, 16'h4000);
        set_op(1, 16'h4040, 16'h4040);
        req_valid = 4'b1001;
        out_ready = 1'b0;
        tick();
        tick();
        req_valid = 4'b0000;
        check("mid_inflight", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_product", 32'(out_product), 32'h0000);
        req_valid = 4'b1010;
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1 check("post_rst_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0000;
        check("post_rst_s1_only", 32'(out_valid), 32'd0);
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_id", 32'(out_id), 32'd1);
        check("post_rst_product", 32'(out_product), 32'h4110);
        tick();

`ifdef BF16_ARB_STATS_EN
        reset_pulse();
        check("stats_rst_op", op_count, 32'd0);
        check("stats_rst_stall", stall_count, 32'd0);
        set_op(0, 16'h3F80, 16'h4000);
        acc = 0;
        for (int c = 0; c < 25; c++) begin
            req_valid = (acc < 10) ? 4'b0001 : 4'b0000;
            out_ready = (c >= 5 && c <= 7) ? 1'b0 : 1'b1;
            #1;
            if (req_valid[0] && req_ready[0]) acc++;
            tick();
        end
        check("stats_op_count", op_count, 32'd10);
        check("stats_stall_count", stall_count, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
